// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 has priority, port 1 has bounded wait, and read returns are routed by tag.
// Optional conflict counter is built only when DMEM_ARB_CONFLICT_CNT_EN is defined.
module dmem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_read_i,
  input  logic [3:0]  m0_wsel_byte_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_read_i,
  input  logic [3:0]  m1_wsel_byte_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_read_o,
  output logic [3:0]  mem_wsel_byte_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] conflict_cnt_o
);

  // Handshake: a request is accepted in the cycle its gnt is high; a denied
  // requester holds req and payload stable until it sees gnt.

  typedef enum logic {PRIO_M0, FORCE_M1} state_t;

  // A zero-width counter is illegal, so MAX_WAIT=0 keeps one unused bit.
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   wait_next;
  logic            gnt0;
  logic            gnt1;
  logic            rd_issue;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_own;
  logic                    ret_vld;
  logic                    ret_own;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= PRIO_M0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (!rst_i) begin
      case (state)
        PRIO_M0: begin
          gnt0 = m0_req_i;
          gnt1 = m1_req_i & ~m0_req_i;
          if (!m1_req_i || gnt1) begin
            wait_next = '0;
          end else if (MAX_WAIT > 0) begin
            if (wait_cnt == CNT_LAST) begin
              state_next = FORCE_M1;
              wait_next  = '0;
            end else begin
              wait_next = wait_cnt + 1'b1;
            end
          end
        end
        FORCE_M1: begin
          // The forced slot is used once or released; it is never held open.
          gnt1       = m1_req_i;
          state_next = PRIO_M0;
          wait_next  = '0;
        end
        default: begin
          state_next = PRIO_M0;
          wait_next  = '0;
        end
      endcase
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;
  assign mem_en_o = gnt0 | gnt1;

  always_comb begin
    mem_addr_o      = 32'd0;
    mem_read_o      = 1'b0;
    mem_wsel_byte_o = 4'd0;
    mem_wdata_o     = 32'd0;
    if (gnt0) begin
      mem_addr_o      = m0_addr_i;
      mem_read_o      = m0_read_i;
      mem_wsel_byte_o = m0_wsel_byte_i;
      mem_wdata_o     = m0_wdata_i;
    end else if (gnt1) begin
      mem_addr_o      = m1_addr_i;
      mem_read_o      = m1_read_i;
      mem_wsel_byte_o = m1_wsel_byte_i;
      mem_wdata_o     = m1_wdata_i;
    end
  end

  assign rd_issue = (gnt0 & m0_read_i) | (gnt1 & m1_read_i);

  // Owner tag: 0 = port 0, 1 = port 1; meaningful only where valid is set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld[0] <= rd_issue;
      pipe_own[0] <= gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign ret_vld = pipe_vld[READ_LATENCY-1] & ~rst_i;
  assign ret_own = pipe_own[READ_LATENCY-1];

  assign m0_rvalid_o = ret_vld & ~ret_own;
  assign m1_rvalid_o = ret_vld & ret_own;
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : 32'd0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : 32'd0;

`ifdef DMEM_ARB_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_cnt <= 32'd0;
    end else if (m0_req_i && m1_req_i && !(&conflict_cnt)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt;
`else
  assign conflict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RL1/MW4, RL2/MW4, RL1/MW0) share one stimulus set.
// A vector table covers the main arbitration cases; hand sequences cover fairness, ordering and reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_read = 1'b0, m1_req = 1'b0, m1_read = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wsel = '0, m1_wsel = '0;
  logic [31:0] mem_rdata = '0;

  logic [2:0]  g0, g1, rv0, rv1, en, rd;
  logic [31:0] rd0 [3];
  logic [31:0] rd1 [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] cc [3];
  logic [3:0]  wsel [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Index 0: READ_LATENCY=1 MAX_WAIT=4; 1: READ_LATENCY=2 MAX_WAIT=4; 2: READ_LATENCY=1 MAX_WAIT=0
  for (genvar k = 0; k < 3; k++) begin : g_dut
    dmem_arbiter #(
      .READ_LATENCY((k == 1) ? 2 : 1),
      .MAX_WAIT    ((k == 2) ? 0 : 4)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_read_i(m0_read),
      .m0_wsel_byte_i(m0_wsel), .m0_wdata_i(m0_wdata),
      .m0_gnt_o(g0[k]), .m0_rvalid_o(rv0[k]), .m0_rdata_o(rd0[k]),
      .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_read_i(m1_read),
      .m1_wsel_byte_i(m1_wsel), .m1_wdata_i(m1_wdata),
      .m1_gnt_o(g1[k]), .m1_rvalid_o(rv1[k]), .m1_rdata_o(rd1[k]),
      .mem_en_o(en[k]), .mem_addr_o(addr[k]), .mem_read_o(rd[k]),
      .mem_wsel_byte_o(wsel[k]), .mem_wdata_o(wdata[k]), .mem_rdata_i(mem_rdata),
      .conflict_cnt_o(cc[k])
    );
  end

  typedef struct packed {
    logic m0_req, m0_read, m1_req, m1_read;
    logic g0, g1, rv0, rv1;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wsel;
    logic        e_read, e_rv0, e_rv1;

    //            m0r m0rd m1r m1rd | g0 g1 rv0 rv1
    vecs[0]  = 8'b1100_1000; // m0 read alone
    vecs[1]  = 8'b0000_0010; // m0 read returns
    vecs[2]  = 8'b0011_0100; // m1 read alone
    vecs[3]  = 8'b1011_1001; // m0 write wins, m1 read returns
    vecs[4]  = 8'b1011_1000;
    vecs[5]  = 8'b1011_1000;
    vecs[6]  = 8'b1011_1000; // fourth denial arms the forced slot
    vecs[7]  = 8'b1011_0100; // forced m1 grant
    vecs[8]  = 8'b1111_1001;
    vecs[9]  = 8'b1100_1010; // m1 drops, wait counter clears
    vecs[10] = 8'b0010_0110; // m1 write alone
    vecs[11] = 8'b0000_0000;
    vecs[12] = 8'b1010_1000;
    vecs[13] = 8'b1010_1000;
    vecs[14] = 8'b1010_1000;
    vecs[15] = 8'b1010_1000;
    vecs[16] = 8'b1000_0000; // forced slot released, nobody granted
    vecs[17] = 8'b1000_1000; // m0 served again

    // Reset state: requests present but grants held low
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    chk("rst_g0", {31'd0, g0[0]}, 32'd0);
    chk("rst_g1", {31'd0, g1[0]}, 32'd0);
    chk("rst_en", {31'd0, en[0]}, 32'd0);
    chk("rst_cc", cc[0], 32'd0);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      m0_req  = vecs[i].m0_req;  m0_read = vecs[i].m0_read;
      m1_req  = vecs[i].m1_req;  m1_read = vecs[i].m1_read;
      m0_addr = 32'h100 + 32'(i * 16);   m1_addr  = 32'h2000 + 32'(i * 16);
      m0_wsel = 4'hF;                    m1_wsel  = 4'h3;
      m0_wdata = 32'h0A0A_0000 + 32'(i); m1_wdata = 32'h1B1B_0000 + 32'(i);
      mem_rdata = (i == 1) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      e_addr = 32'd0; e_wdata = 32'd0; e_wsel = 4'd0; e_read = 1'b0;
      if (vecs[i].g0) begin
        e_addr = m0_addr; e_wdata = m0_wdata; e_wsel = m0_wsel; e_read = m0_read;
      end else if (vecs[i].g1) begin
        e_addr = m1_addr; e_wdata = m1_wdata; e_wsel = m1_wsel; e_read = m1_read;
      end
      chk($sformatf("v%0d_g0", i), {31'd0, g0[0]}, {31'd0, vecs[i].g0});
      chk($sformatf("v%0d_g1", i), {31'd0, g1[0]}, {31'd0, vecs[i].g1});
      chk($sformatf("v%0d_en", i), {31'd0, en[0]}, {31'd0, vecs[i].g0 | vecs[i].g1});
      chk($sformatf("v%0d_addr", i), addr[0], e_addr);
      chk($sformatf("v%0d_read", i), {31'd0, rd[0]}, {31'd0, e_read});
      chk($sformatf("v%0d_wsel", i), {28'd0, wsel[0]}, {28'd0, e_wsel});
      chk($sformatf("v%0d_wdata", i), wdata[0], e_wdata);
      chk($sformatf("v%0d_rv0", i), {31'd0, rv0[0]}, {31'd0, vecs[i].rv0});
      chk($sformatf("v%0d_rv1", i), {31'd0, rv1[0]}, {31'd0, vecs[i].rv1});
      chk($sformatf("v%0d_rd0", i), rd0[0], vecs[i].rv0 ? mem_rdata : 32'd0);
      chk($sformatf("v%0d_rd1", i), rd1[0], vecs[i].rv1 ? mem_rdata : 32'd0);
    end

    // Continuous dual requests: period-5 fairness vs strict priority
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1 m0_req = 1'b1; m1_req = 1'b1; m0_read = 1'b0; m1_read = 1'b0;
      @(negedge clk);
      chk($sformatf("fair%0d_g1", c), {31'd0, g1[0]}, (c % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("fair%0d_g0", c), {31'd0, g0[0]}, (c % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("strict%0d_g1", c), {31'd0, g1[2]}, 32'd0);
      chk($sformatf("strict%0d_g0", c), {31'd0, g0[2]}, 32'd1);
    end

    // Alternating owners with READ_LATENCY=2: returns stay in order
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      m0_req = (c == 0 || c == 2); m0_read = 1'b1;
      m1_req = (c == 1);           m1_read = 1'b1;
      m0_addr = (c == 0) ? 32'h10 : 32'h30;
      m1_addr = 32'h20;
      mem_rdata = 32'h5000_0000 + 32'(c);
      @(negedge clk);
      e_rv0 = (c == 2 || c == 4);
      e_rv1 = (c == 3);
      if (c < 3) begin
        chk($sformatf("alt%0d_en", c), {31'd0, en[1]}, 32'd1);
        chk($sformatf("alt%0d_addr", c), addr[1], (c == 0) ? 32'h10 : (c == 1) ? 32'h20 : 32'h30);
      end
      chk($sformatf("alt%0d_rv0", c), {31'd0, rv0[1]}, {31'd0, e_rv0});
      chk($sformatf("alt%0d_rv1", c), {31'd0, rv1[1]}, {31'd0, e_rv1});
      chk($sformatf("alt%0d_rd0", c), rd0[1], e_rv0 ? 32'h5000_0000 + 32'(c) : 32'd0);
      chk($sformatf("alt%0d_rd1", c), rd1[1], e_rv1 ? 32'h5000_0000 + 32'(c) : 32'd0);
    end

    // Reset lands on the cycle after an m0 read grant: the read is dropped
    do_reset();
    @(posedge clk);
    #1 m0_req = 1'b1; m0_read = 1'b1; m0_addr = 32'h40; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("mid_g0", {31'd0, g0[0]}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    chk("mid_rst_g0", {29'd0, g0}, 32'd0);
    chk("mid_rst_g1", {29'd0, g1}, 32'd0);
    chk("mid_rst_en", {29'd0, en}, 32'd0);
    chk("mid_rst_rv0", {29'd0, rv0}, 32'd0);
    chk("mid_rst_rd0", rd0[0], 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("post%0d_rv0", c), {29'd0, rv0}, 32'd0);
      chk($sformatf("post%0d_rv1", c), {29'd0, rv1}, 32'd0);
    end

    // Conflict counter: seven dual-request cycles, then reset clears it
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1 m0_req = 1'b1; m1_req = 1'b1; m0_read = 1'b0; m1_read = 1'b0;
    end
    @(posedge clk);
    #1 m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
`ifdef DMEM_ARB_CONFLICT_CNT_EN
    chk("cc_after7", cc[0], 32'd7);
`else
    chk("cc_tied", cc[0], 32'd0);
`endif
    #1 rst = 1'b1;
    #1 chk("cc_reset", cc[0], 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the core load/store unit and port 1 is a secondary master such as debug or DMA.
- Grants are combinational and issued the same cycle. Port 0 has priority, and a bounded-wait counter prevents port 1 from starving.
- Each memory access is tagged with its owner so read data returning after the fixed memory latency is routed back to the right requester.
- Sits between the LSU and the data memory inside the core top.

Parameters:
- READ_LATENCY, 1, cycles from an accepted read to valid mem_rdata_i; legal range 1..4.
- MAX_WAIT, 4, consecutive denied cycles of port 1 before it is forced a grant; 0 disables the protection (strict port-0 priority).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- m0_req_i  in  1  port 0 access request
- m0_addr_i  in  32  port 0 byte address
- m0_read_i  in  1  port 0: 1 = read, 0 = write
- m0_wsel_byte_i  in  4  port 0 byte write enables
- m0_wdata_i  in  32  port 0 write data, already lane-aligned
- m0_gnt_o  out  1  port 0 request accepted this cycle
- m0_rvalid_o  out  1  port 0 read data valid
- m0_rdata_o  out  32  port 0 read data
- m1_req_i, m1_addr_i, m1_read_i, m1_wsel_byte_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same widths and meaning for port 1
- mem_en_o  out  1  memory enable
- mem_addr_o  out  32  memory address
- mem_read_o  out  1  memory read strobe
- mem_wsel_byte_o  out  4  memory byte write enables
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data
- conflict_cnt_o  out  32  performance counter (see Optional Feature)

Behaviour:
- State machine, reset state PRIO_M0:
  - PRIO_M0: m0_req_i wins; otherwise m1_req_i wins.
  - FORCE_M1: m1 wins if m1_req_i is high, and m0 is denied.
- Wait counter (width $clog2(MAX_WAIT+1), reset 0):
  - In PRIO_M0, increments each cycle m1_req_i is high and m1 is not granted.
  - Cleared on any m1 grant or when m1_req_i is low.
  - When the counter equals MAX_WAIT-1 and m1 is denied again, the next state is FORCE_M1.
- Leaving FORCE_M1: return to PRIO_M0 with counter 0 after the m1 grant, or immediately if m1_req_i is low (the forced slot is released, not held).
- MAX_WAIT=0: the FSM stays in PRIO_M0 permanently.
- Memory-side drive:
  - mem_* are driven combinationally from the granted port.
  - With no grant: mem_en_o=0 and all other mem_* outputs are 0.
  - mem_en_o equals m0_gnt_o | m1_gnt_o. At most one grant is high in any cycle.
- Return path:
  - A READ_LATENCY-deep shift register carries {valid, owner}; valid is set only for granted reads.
  - mX_rvalid_o is high when the stage-out entry is valid and its owner is X.
  - mX_rdata_o equals mem_rdata_i when mX_rvalid_o is high, else 0.
- Writes complete in the grant cycle and produce no rvalid.
- Back-to-back grants are allowed every cycle, including alternating owners. Tags keep returns in order.
- Denied requesters must hold their request and payload stable until granted.
- Reset (asynchronous, active high):
  - FSM returns to PRIO_M0, counter to 0, tag pipe to all-invalid, conflict_cnt_o to 0.
  - m0_gnt_o, m1_gnt_o and mem_en_o are forced to 0 while rst_i is high; all rvalid and rdata outputs are 0.
  - A read in flight when reset asserts is dropped; no rvalid is emitted after reset releases.

Optional Feature:
- Macro DMEM_ARB_CONFLICT_CNT_EN.
- Defined: conflict_cnt_o increments in every cycle where m0_req_i and m1_req_i are both high. It saturates at 32'hFFFFFFFF and is cleared by reset.
- Undefined: no counter register is built and conflict_cnt_o is tied to 0.

Test Plan:
- Reset release, m0 read to 0x100 only, READ_LATENCY=1, mem_rdata_i=0xDEADBEEF: m0_gnt_o=1 and mem_addr_o=0x100 in cycle 0; m0_rvalid_o=1 and m0_rdata_o=0xDEADBEEF in cycle 1; m1_rvalid_o stays 0.
- Both ports request continuously, MAX_WAIT=4: m0 granted cycles 0-3, m1 granted cycle 4, m0 again from cycle 5. Pattern repeats with period 5.
- MAX_WAIT=0, both ports request for 20 cycles: m1_gnt_o never asserts.
- Alternating reads m0@0x10, m1@0x20, m0@0x30 on consecutive cycles, READ_LATENCY=2: rvalid pulses arrive 2 cycles later in order m0, m1, m0, each with its own data.
- m1 forced slot with m1_req_i dropping in that cycle: no grant is issued, the FSM returns to PRIO_M0, and m0 is granted in the next cycle.
- rst_i asserted the cycle after an m0 read grant: no m0_rvalid_o ever appears; with DMEM_ARB_CONFLICT_CNT_EN defined, 7 cycles of dual requests make conflict_cnt_o=7, and reset clears it to 0.
